ysyx_22050854_ifu_fetch: RTL and testbench

Instruction fetch stage of the NPC core, directly upstream of decode and the immediate generator. It owns the PC, issues one outstanding request at a time to instruction memory over a valid/ready request plus response-valid interface, and presents {pc, instr} in an IF/ID output register to decode under a valid/ready handshake. It supports decode back-pressure through a one-entry skid buffer, and redirect (branch/jump/trap) with kill of any in-flight fetch.

---
 rtl/ysyx_22050854_ifu_fetch.sv | 85 ++++++++
 tb/tb_ysyx_22050854_ifu_fetch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_ifu_fetch.sv
// ysyx_22050854_ifu_fetch: PC owner issuing one imem request at a time into an IF/ID register backed by a one-entry skid buffer
module ysyx_22050854_ifu_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, r_req_pc, r_skid_pc, r_if_pc;
    logic [31:0] r_skid_instr, r_if_instr;
    logic        r_kill, w_kill_nxt, r_if_valid;
    logic        w_fire, w_resp, w_load, w_skid, w_unskid;
    assign imem_req_valid = r_state == S_REQ;
    assign imem_req_addr  = r_pc;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instr       = r_if_instr;
    assign w_fire   = r_state == S_REQ && imem_req_ready;
    assign w_resp   = r_state == S_WAIT && imem_resp_valid;
    assign w_load   = w_resp && !r_kill && !redirect_valid && (!r_if_valid || id_ready);
    assign w_skid   = w_resp && !r_kill && !redirect_valid && r_if_valid && !id_ready;
    assign w_unskid = r_state == S_HOLD && id_ready && !redirect_valid;
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        case (r_state)
            S_REQ:   w_state_nxt = w_fire ? S_WAIT : S_REQ;
            S_WAIT:  w_state_nxt = imem_resp_valid ? (w_skid ? S_HOLD : S_REQ) : S_WAIT;
            default: w_state_nxt = (redirect_valid || id_ready) ? S_REQ : S_HOLD;
        endcase
        // a redirect kills whatever request is or becomes outstanding without its response yet
        w_kill_nxt = redirect_valid ? (w_fire || (r_state == S_WAIT && !imem_resp_valid))
                                    : (r_kill && !w_resp);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_kill       <= 1'b0;
            r_pc         <= RESET_PC;
            r_req_pc     <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_instr   <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (redirect_valid) r_pc <= redirect_pc & ~64'h3;
            else if (w_fire) r_pc <= r_pc + 64'd4;
            if (w_fire) r_req_pc <= r_pc;
            if (w_skid) begin
                r_skid_pc    <= r_req_pc;
                r_skid_instr <= imem_resp_data;
            end
            if (redirect_valid) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end else if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_pc;
                r_if_instr <= imem_resp_data;
            end else if (w_unskid) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_skid_pc;
                r_if_instr <= r_skid_instr;
            end else if (id_ready) begin
                r_if_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050854_ifu_fetch.sv
// tb_ysyx_22050854_ifu_fetch: directed checks of fetch, back-pressure, redirect/kill and reset against a small imem model
module tb_ysyx_22050854_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_dly = 1;
    int          mem_cnt = 0;
    bit          mem_pend = 0;
    logic [63:0] mem_addr = '0;
    ysyx_22050854_ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0093;
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // one clock edge; the memory model answers mem_dly cycles after an accepted request
    task automatic step();
        bit          acc;
        bit          rst_seen;
        logic [63:0] a;
        acc      = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1) && (rst_n === 1'b1);
        rst_seen = rst_n !== 1'b1;
        a        = imem_req_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rst_seen) mem_pend = 0;
        if (acc) begin
            mem_pend = 1;
            mem_addr = a;
            mem_cnt  = mem_dly;
        end
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(mem_addr);
                mem_pend        = 0;
            end
        end
    endtask
    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        step(); step();
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 64'h13);
        chk("rst_req_valid", imem_req_valid, 1);
        chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
        rst_n = 1'b1;
        step();
        chk("wait_req_valid", imem_req_valid, 0);
        step();
        chk("first_valid", if_valid, 1);
        chk("first_pc", if_pc, 64'h8000_0000);
        chk("first_instr", if_instr, 64'h93);
        chk("next_req_addr", imem_req_addr, 64'h8000_0004);
        id_ready = 1'b0;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_no_req", imem_req_valid, 0);
            chk("hold_out_pc", if_pc, 64'h8000_0000);
            chk("hold_out_valid", if_valid, 1);
        end
        id_ready = 1'b1;
        step();
        chk("skid_valid", if_valid, 1);
        chk("skid_pc", if_pc, 64'h8000_0004);
        chk("skid_instr", if_instr, 64'h97);
        chk("skid_req_addr", imem_req_addr, 64'h8000_0008);
        step();
        chk("drain_valid", if_valid, 0);
        chk("drain_pc_hold", if_pc, 64'h8000_0004);
        step();
        chk("third_pc", if_pc, 64'h8000_0008);
        chk("third_valid", if_valid, 1);
        mem_dly = 3;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        chk("rdw_valid", if_valid, 0);
        chk("rdw_instr", if_instr, 64'h13);
        chk("rdw_req_valid", imem_req_valid, 0);
        step();
        chk("rdw_stale_dropped", if_valid, 0);
        chk("rdw_req_valid2", imem_req_valid, 1);
        chk("rdw_req_addr", imem_req_addr, 64'h8000_1000);
        mem_dly = 1; id_ready = 1'b0;
        step(); step();
        chk("tgt_pc", if_pc, 64'h8000_1000);
        chk("tgt_instr", if_instr, 64'h1093);
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; id_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("rdr_valid", if_valid, 0);
        chk("rdr_instr", if_instr, 64'h13);
        chk("rdr_req_valid", imem_req_valid, 1);
        chk("rdr_req_addr", imem_req_addr, 64'h8000_2000);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        step();
        redirect_valid = 1'b0;
        chk("rda_wait", imem_req_valid, 0);
        step();
        chk("rda_dropped", if_valid, 0);
        chk("rda_req_addr", imem_req_addr, 64'h8000_3000);
        step(); step();
        chk("rda_new_valid", if_valid, 1);
        chk("rda_new_pc", if_pc, 64'h8000_3000);
        chk("rda_new_instr", if_instr, 64'h3093);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_4007;
        step();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        chk("rdq_req_valid", imem_req_valid, 1);
        chk("rdq_req_addr", imem_req_addr, 64'h8000_4004);
        chk("rdq_valid", if_valid, 0);
        id_ready = 1'b0;
        step(); step(); step(); step();
        chk("pre_rst_hold", imem_req_valid, 0);
        chk("pre_rst_valid", if_valid, 1);
        chk("pre_rst_pc", if_pc, 64'h8000_4004);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; id_ready = 1'b1;
        chk("mid_rst_valid", if_valid, 0);
        chk("mid_rst_instr", if_instr, 64'h13);
        chk("mid_rst_req_valid", imem_req_valid, 1);
        chk("mid_rst_req_addr", imem_req_addr, 64'h8000_0000);
        step(); step();
        chk("post_rst_pc", if_pc, 64'h8000_0000);
        chk("post_rst_instr", if_instr, 64'h93);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
